// File: rtl/fir_seq_pkg.sv
// Shared constants, state encoding and default tap shifts for the
// time-multiplexed 5-tap shift-and-add FIR sequencer.
package fir_seq_pkg;

  localparam int NTAPS = 5;
  localparam int DW    = 8;
  localparam int OW    = 10;
  localparam int TW    = 3;  // tap index / shift amount width
  localparam int SW    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [SW-1:0] DEFAULT_SHIFT [NTAPS] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

  // One tap's contribution, zero-extended to the accumulator width.
  function automatic logic [OW-1:0] tap_term(input logic [DW-1:0] d,
                                             input logic [SW-1:0] sh);
    return OW'(d >> sh);
  endfunction

endpackage

// File: rtl/fir_seq_delay_line.sv
// NTAPS x DW sample delay line: shift on enable, synchronous clear,
// and one combinational indexed read port for the shared tap unit.
module fir_seq_delay_line
  import fir_seq_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          shift_en,
  input  logic [DW-1:0] din,
  input  logic [TW-1:0] rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] d_q [NTAPS];
  logic [DW-1:0] d_d [NTAPS];

  always_comb begin
    d_d = d_q;
    if (clr) begin
      for (int k = 0; k < NTAPS; k++) d_d[k] = '0;
    end else if (shift_en) begin
      d_d[0] = din;
      for (int k = 1; k < NTAPS; k++) d_d[k] = d_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    d_q <= d_d;
  end

  // Out-of-range indices read as zero rather than aliasing a tap.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (rd_idx == TW'(k)) rd_data = d_q[k];
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer stepping one shift-and-accumulate unit across the FIR taps.
// Define FIR_SEQ_CFG_EN to make the per-tap right shifts writable.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample handshake
// ACC   | one tap per cycle added into acc, tap 0..4
// OUT   | out_valid high, dataout held until out_ready
module fir_seq_ctrl
  import fir_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] dataout,
  output logic          busy
`ifdef FIR_SEQ_CFG_EN
  ,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_tap,
  input  logic [2:0]    cfg_shift
`endif
);

  state_e        state_q, state_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [OW-1:0] acc_q, acc_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] dataout_q, dataout_d;
  logic          busy_q, busy_d;

  logic          hs;
  logic [DW-1:0] rd_data;
  logic [SW-1:0] sh_sel;
  logic [OW-1:0] acc_sum;
  logic [SW-1:0] sh_q [NTAPS];

  assign hs = in_valid && in_ready_q && (state_q == IDLE);

  fir_seq_delay_line u_delay_line (
    .clk      (clk),
    .clr      (rst),
    .shift_en (hs),
    .din      (x),
    .rd_idx   (tap_q),
    .rd_data  (rd_data)
  );

`ifdef FIR_SEQ_CFG_EN
  logic          cfg_ok;
  logic [SW-1:0] sh_d [NTAPS];

  // Writes only land in a quiet IDLE cycle; a same-cycle sample wins.
  assign cfg_ok = cfg_we && (state_q == IDLE) && (cfg_tap <= 3'(NTAPS-1)) && !hs;

  always_comb begin
    sh_d = sh_q;
    if (cfg_ok) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (cfg_tap == 3'(k)) sh_d[k] = cfg_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= DEFAULT_SHIFT;
    else     sh_q <= sh_d;
  end
`else
  always_comb begin
    sh_q = DEFAULT_SHIFT;
  end
`endif

  always_comb begin
    sh_sel = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (tap_q == TW'(k)) sh_sel = sh_q[k];
    end
  end

  assign acc_sum = acc_q + tap_term(rd_data, sh_sel);

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dataout_d   = dataout_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d    = ACC;
          tap_d      = '0;
          acc_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ACC: begin
        acc_d = acc_sum;
        if (tap_q == TW'(NTAPS-1)) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          dataout_d   = acc_sum;
        end else begin
          tap_d = tap_q + TW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dataout_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dataout_q   <= dataout_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dataout   = dataout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: directed and randomized samples checked against
// a history-of-samples reference model; cfg tests need FIR_SEQ_CFG_EN.
module tb_fir_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] x = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic       busy;
  logic [9:0] dataout;
`ifdef FIR_SEQ_CFG_EN
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_tap = 3'd0;
  logic [2:0] cfg_shift = 3'd0;
`endif

  int checks = 0;
  int errors = 0;
  int hist [5];
  int sh_m [5];

  always #5 clk = ~clk;

  fir_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .busy      (busy)
`ifdef FIR_SEQ_CFG_EN
    ,
    .cfg_we    (cfg_we),
    .cfg_tap   (cfg_tap),
    .cfg_shift (cfg_shift)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sum of the last five accepted samples, each shifted by its tap amount.
  function automatic int model_result();
    int s = 0;
    for (int k = 0; k < 5; k++) s += hist[k] >> sh_m[k];
    return s % 1024;
  endfunction

  task automatic model_push(input int v);
    for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 5; k++) hist[k] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input int stall, output int res);
    int exp;
    check("idle_in_ready", 32'(in_ready), 1);
    check("idle_busy", 32'(busy), 0);
    in_valid = 1'b1;
    x = v[7:0];
    step();
    model_push(v);
    exp = model_result();
    for (int c = 1; c <= 5; c++) begin
      check("acc_in_ready", 32'(in_ready), 0);
      check("acc_out_valid", 32'(out_valid), 0);
      check("acc_busy", 32'(busy), 1);
      in_valid = 1'($urandom_range(0, 1));
      x = 8'($urandom_range(0, 255));
      step();
    end
    in_valid = 1'b0;
    check("out_valid_n6", 32'(out_valid), 1);
    check("out_in_ready", 32'(in_ready), 0);
    check("dataout", 32'(dataout), exp);
    res = int'(dataout);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      x = 8'($urandom_range(0, 255));
      step();
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_dataout", 32'(dataout), exp);
      check("stall_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("done_out_valid", 32'(out_valid), 0);
    check("done_in_ready", 32'(in_ready), 1);
    check("done_busy", 32'(busy), 0);
  endtask

  initial begin
    int r;
    int imp_exp [7];
    imp_exp = '{4, 8, 16, 32, 64, 0, 0};
    model_clear();
    sh_m = '{5, 4, 3, 2, 1};

    rst = 1'b1;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_dataout", 32'(dataout), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      send((i == 0) ? 128 : 0, 0, r);
      check("impulse", 32'(r), 32'(imp_exp[i]));
    end

    for (int i = 0; i < 5; i++) send(255, 0, r);
    check("dc_255", 32'(r), 243);

    send(int'($urandom_range(0, 255)), 10, r);

    // Reset during the third accumulate cycle drops the partial result.
    in_valid = 1'b1;
    x = 8'($urandom_range(0, 255));
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    send(200, 0, r);
    check("midrst_200", 32'(r), 6);

    for (int i = 0; i < 12; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step();
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), r);
    end

`ifdef FIR_SEQ_CFG_EN
    for (int k = 0; k < 5; k++) begin
      cfg_we = 1'b1;
      cfg_tap = 3'(k);
      cfg_shift = 3'd0;
      step();
      sh_m[k] = 0;
    end
    cfg_we = 1'b0;
    for (int i = 0; i < 5; i++) send(255, 0, r);
    check("cfg_sh0_dc", 32'(r), 251);

    cfg_we = 1'b1;
    cfg_tap = 3'd5;
    cfg_shift = 3'd7;
    step();
    cfg_we = 1'b0;
    send(255, 0, r);
    check("cfg_tap5_ignored", 32'(r), 251);

    // Write held through a handshake, ACC and OUT must never land.
    cfg_we = 1'b1;
    cfg_tap = 3'd0;
    cfg_shift = 3'd7;
    send(255, 2, r);
    cfg_we = 1'b0;
    check("cfg_hs_dropped", 32'(r), 251);

    cfg_we = 1'b1;
    cfg_tap = 3'd2;
    cfg_shift = 3'd3;
    step();
    cfg_we = 1'b0;
    sh_m[2] = 3;
    for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), r);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
